dma_int_status_queue: RTL and testbench

Interrupt controller that sits downstream of the DMA interrupt-status mux. It filters status records (op done, write/read error, descriptor-not-valid error) against a software mask and queues them in a small FIFO. It drives a level interrupt to the host and exposes the head record to the register block, which pops or flushes it. It also tracks dropped records when the queue is full.

---
 rtl/dma_int_status_queue_if.sv | 51 +++++
 rtl/dma_int_status_queue.sv | 131 +++++++++++++
 tb/tb_dma_int_status_queue.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dma_int_status_queue_if.sv
// Status-record and register-side bundle for the DMA interrupt status queue.
// The slave modport is the queue; the master modport is the mux/register side.
interface dma_int_status_queue_if #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH_WIDTH  = 2
);
  logic                         stsValid;
  logic                         stsOpDone;
  logic                         stsWrError;
  logic                         stsRdError;
  logic                         stsNValidError;
  logic [NUM_INT_BDS_WIDTH-1:0] stsIntDscrptrNum;
  logic                         stsExtDscrptr;
  logic                         stsStrDscrptr;
  logic [31:0]                  stsExtDscrptrAddr;
  logic                         stsReady;
  logic [3:0]                   intMask;
  logic                         irqEnable;
  logic                         popReq;
  logic                         clearAll;
  logic                         headValid;
  logic [3:0]                   headEvents;
  logic [NUM_INT_BDS_WIDTH-1:0] headIntDscrptrNum;
  logic                         headExtDscrptr;
  logic                         headStrDscrptr;
  logic [31:0]                  headExtDscrptrAddr;
  logic [FIFO_DEPTH_WIDTH:0]    fifoCount;
  logic                         overflow;
  logic [7:0]                   dropCount;
  logic                         irq;

  modport slave (
    input  stsValid, stsOpDone, stsWrError, stsRdError,
    input  stsNValidError, stsIntDscrptrNum, stsExtDscrptr,
    input  stsStrDscrptr, stsExtDscrptrAddr,
    input  intMask, irqEnable, popReq, clearAll,
    output stsReady, headValid, headEvents, headIntDscrptrNum,
    output headExtDscrptr, headStrDscrptr, headExtDscrptrAddr,
    output fifoCount, overflow, dropCount, irq
  );

  modport master (
    output stsValid, stsOpDone, stsWrError, stsRdError,
    output stsNValidError, stsIntDscrptrNum, stsExtDscrptr,
    output stsStrDscrptr, stsExtDscrptrAddr,
    output intMask, irqEnable, popReq, clearAll,
    input  stsReady, headValid, headEvents, headIntDscrptrNum,
    input  headExtDscrptr, headStrDscrptr, headExtDscrptrAddr,
    input  fifoCount, overflow, dropCount, irq
  );
endinterface

// File: rtl/dma_int_status_queue.sv
// Masked DMA status-record queue with drop tracking and a level irq.
// Head record is a combinational read of the oldest entry, zero when empty.
module dma_int_status_queue #(
  parameter int NUM_INT_BDS_WIDTH = 2,
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_WIDTH  = 2
) (
  input  logic clock,
  input  logic resetn,
  dma_int_status_queue_if.slave bus
);
  localparam int LP_W = 4 + NUM_INT_BDS_WIDTH + 2 + 32;
  localparam logic [FIFO_DEPTH_WIDTH:0] LP_FULL =
    (FIFO_DEPTH_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [FIFO_DEPTH_WIDTH:0] LP_CONE =
    (FIFO_DEPTH_WIDTH+1)'(1);
  localparam logic [FIFO_DEPTH_WIDTH-1:0] LP_PONE =
    FIFO_DEPTH_WIDTH'(1);

  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_st_e;

  logic [3:0]                  w_ev;
  logic                        w_qual;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_drop;
  logic                        w_irq_cond;
  logic [FIFO_DEPTH_WIDTH:0]   w_count_nxt;
  logic                        w_ovf_nxt;
  logic [LP_W-1:0]             w_rec;
  logic [LP_W-1:0]             w_head;

  logic [FIFO_DEPTH_WIDTH-1:0] r_wr;
  logic [FIFO_DEPTH_WIDTH-1:0] r_rd;
  logic [FIFO_DEPTH_WIDTH:0]   r_count;
  logic                        r_ovf;
  logic [7:0]                  r_drop;
  logic                        r_irq;
  irq_st_e                     r_state;
  logic [LP_W-1:0]             r_mem [FIFO_DEPTH];

  assign w_ev = {bus.stsNValidError, bus.stsRdError,
                 bus.stsWrError, bus.stsOpDone};
  assign w_qual  = bus.stsValid && (|(w_ev & bus.intMask));
  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);

  // clearAll swallows any same-cycle push, pop or drop
  assign w_push = w_qual && !w_full && !bus.clearAll;
  assign w_drop = w_qual &&  w_full && !bus.clearAll;
  assign w_pop  = bus.popReq && !w_empty && !bus.clearAll;

  assign w_rec = {w_ev, bus.stsIntDscrptrNum, bus.stsExtDscrptr,
                  bus.stsStrDscrptr, bus.stsExtDscrptrAddr};

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      bus.clearAll:      w_count_nxt = '0;
      w_push && !w_pop:  w_count_nxt = r_count + LP_CONE;
      w_pop  && !w_push: w_count_nxt = r_count - LP_CONE;
      default:           w_count_nxt = r_count;
    endcase
  end

  assign w_ovf_nxt  = !bus.clearAll && (r_ovf || w_drop);
  assign w_irq_cond = bus.irqEnable &&
                      ((w_count_nxt != '0) || w_ovf_nxt);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      if (bus.clearAll) begin
        r_wr   <= '0;
        r_rd   <= '0;
        r_drop <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + LP_PONE;
        if (w_pop)  r_rd <= r_rd + LP_PONE;
        if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Storage needs no reset: head is masked to zero while empty
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= w_rec;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IRQ_IDLE;
      r_irq   <= 1'b0;
    end else begin
      unique case (r_state)
        IRQ_IDLE: if (w_irq_cond) begin
          r_state <= IRQ_ACTIVE;
          r_irq   <= 1'b1;
        end
        IRQ_ACTIVE: if (!w_irq_cond) begin
          r_state <= IRQ_IDLE;
          r_irq   <= 1'b0;
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd];

  assign {bus.headEvents, bus.headIntDscrptrNum, bus.headExtDscrptr,
          bus.headStrDscrptr, bus.headExtDscrptrAddr} = w_head;
  assign bus.headValid = !w_empty;
  assign bus.stsReady  = !w_full;
  assign bus.fifoCount = r_count;
  assign bus.overflow  = r_ovf;
  assign bus.dropCount = r_drop;
  assign bus.irq       = r_irq;
endmodule

// File: tb/tb_dma_int_status_queue.sv
// Randomized bench for dma_int_status_queue against a queue-based model.
// Directed scenarios pin the model with literal expectations.
module tb_dma_int_status_queue;
  logic clock;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  dma_int_status_queue_if #(.NUM_INT_BDS_WIDTH(2), .FIFO_DEPTH_WIDTH(2)) bus ();

  dma_int_status_queue #(
    .NUM_INT_BDS_WIDTH(2), .FIFO_DEPTH(4), .FIFO_DEPTH_WIDTH(2)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  ev;
    logic [1:0]  num;
    logic        ext;
    logic        str;
    logic [31:0] addr;
  } rec_t;

  rec_t     q[$];
  logic     m_ovf;
  int       m_drop;
  logic     m_irq;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: queue semantics straight from the behavioural rules
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_ovf  = 1'b0;
      m_drop = 0;
      m_irq  = 1'b0;
    end else begin
      logic [3:0] ev;
      logic       qual;
      logic       full;
      rec_t       r;
      ev = {bus.stsNValidError, bus.stsRdError, bus.stsWrError, bus.stsOpDone};
      qual = bus.stsValid && ((ev & bus.intMask) != 4'h0);
      if (bus.clearAll) begin
        q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        full = (q.size() == 4);
        if (bus.popReq && q.size() > 0) void'(q.pop_front());
        if (qual) begin
          if (full) begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
          end else begin
            r.ev = ev; r.num = bus.stsIntDscrptrNum;
            r.ext = bus.stsExtDscrptr; r.str = bus.stsStrDscrptr;
            r.addr = bus.stsExtDscrptrAddr;
            q.push_back(r);
          end
        end
      end
      m_irq = bus.irqEnable && (q.size() != 0 || m_ovf);
    end
  end

  always @(negedge clock) begin
    if (resetn) begin
      rec_t h;
      h = '{ev: 4'h0, num: 2'h0, ext: 1'b0, str: 1'b0, addr: 32'h0};
      if (q.size() > 0) h = q[0];
      chk("m_count", 64'(bus.fifoCount), 64'(q.size()));
      chk("m_ready", 64'(bus.stsReady), 64'(q.size() != 4));
      chk("m_hvalid", 64'(bus.headValid), 64'(q.size() != 0));
      chk("m_head", {bus.headEvents, bus.headIntDscrptrNum, bus.headExtDscrptr,
                     bus.headStrDscrptr, bus.headExtDscrptrAddr},
          {h.ev, h.num, h.ext, h.str, h.addr});
      chk("m_ovf", 64'(bus.overflow), 64'(m_ovf));
      chk("m_drop", 64'(bus.dropCount), 64'(m_drop));
      chk("m_irq", 64'(bus.irq), 64'(m_irq));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    bus.stsValid = 1'b0;
    bus.popReq   = 1'b0;
    bus.clearAll = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] ev,
                       input logic [1:0] num, input logic [31:0] a,
                       input logic p, input logic c);
    bus.stsValid = v;
    {bus.stsNValidError, bus.stsRdError, bus.stsWrError, bus.stsOpDone} = ev;
    bus.stsIntDscrptrNum  = num;
    bus.stsExtDscrptr     = 1'($urandom);
    bus.stsStrDscrptr     = 1'($urandom);
    bus.stsExtDscrptrAddr = a;
    bus.popReq   = p;
    bus.clearAll = c;
    tick();
  endtask

  task automatic send(input logic [31:0] a);
    drive(1'b1, 4'b0001, 2'd1, a, 1'b0, 1'b0);
  endtask

  task automatic pop_chk(input logic [31:0] a);
    chk("pop_order", 64'(bus.headExtDscrptrAddr), 64'(a));
    drive(1'b0, 4'h0, 2'd0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    bus.intMask = 4'hF;
    bus.irqEnable = 1'b1;
    bus.stsValid = 1'b0; bus.popReq = 1'b0; bus.clearAll = 1'b0;
    {bus.stsNValidError, bus.stsRdError, bus.stsWrError, bus.stsOpDone} = 4'h0;
    bus.stsIntDscrptrNum = 2'd0; bus.stsExtDscrptr = 1'b0;
    bus.stsStrDscrptr = 1'b0; bus.stsExtDscrptrAddr = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 64'(bus.stsReady), 64'd1);
    chk("rst_count", 64'(bus.fifoCount), 64'd0);
    chk("rst_head", 64'(bus.headValid), 64'd0);
    resetn = 1'b1;
    tick();

    drive(1'b1, 4'b0001, 2'd2, 32'h1000_0040, 1'b0, 1'b0);
    chk("t1_hvalid", 64'(bus.headValid), 64'd1);
    chk("t1_events", 64'(bus.headEvents), 64'h1);
    chk("t1_num", 64'(bus.headIntDscrptrNum), 64'd2);
    chk("t1_addr", 64'(bus.headExtDscrptrAddr), 64'h1000_0040);
    chk("t1_count", 64'(bus.fifoCount), 64'd1);
    chk("t1_irq", 64'(bus.irq), 64'd1);
    drive(1'b0, 4'h0, 2'd0, 32'h0, 1'b1, 1'b0);
    chk("t1_pcount", 64'(bus.fifoCount), 64'd0);
    chk("t1_pirq", 64'(bus.irq), 64'd0);
    chk("t1_paddr", 64'(bus.headExtDscrptrAddr), 64'd0);

    bus.intMask = 4'b0001;
    drive(1'b1, 4'b0010, 2'd0, 32'h55, 1'b0, 1'b0);
    chk("t2_count", 64'(bus.fifoCount), 64'd0);
    chk("t2_drop", 64'(bus.dropCount), 64'd0);
    chk("t2_irq", 64'(bus.irq), 64'd0);

    bus.intMask = 4'hF;
    for (int i = 1; i <= 4; i++) send(32'(i * 16));
    chk("t3_ready", 64'(bus.stsReady), 64'd0);
    send(32'h99);
    chk("t3_ovf", 64'(bus.overflow), 64'd1);
    chk("t3_drop", 64'(bus.dropCount), 64'd1);
    for (int i = 1; i <= 4; i++) pop_chk(32'(i * 16));
    chk("t3_irq", 64'(bus.irq), 64'd1);

    for (int i = 5; i <= 8; i++) send(32'(i * 16));
    drive(1'b1, 4'b0100, 2'd3, 32'hAA, 1'b1, 1'b0);
    chk("t4_count", 64'(bus.fifoCount), 64'd3);
    chk("t4_drop", 64'(bus.dropCount), 64'd2);
    send(32'h90);
    chk("t4_wrap", 64'(bus.fifoCount), 64'd4);
    for (int i = 6; i <= 9; i++) pop_chk(32'(i * 16));

    send(32'hA0);
    send(32'hB0);
    drive(1'b1, 4'b1000, 2'd1, 32'hC0, 1'b0, 1'b1);
    chk("t5_count", 64'(bus.fifoCount), 64'd0);
    chk("t5_ovf", 64'(bus.overflow), 64'd0);
    chk("t5_drop", 64'(bus.dropCount), 64'd0);
    chk("t5_irq", 64'(bus.irq), 64'd0);
    chk("t5_hvalid", 64'(bus.headValid), 64'd0);

    for (int i = 0; i < 4; i++) send(32'(i));
    bus.stsValid = 1'b1;
    {bus.stsNValidError, bus.stsRdError, bus.stsWrError, bus.stsOpDone} = 4'b0001;
    repeat (300) @(posedge clock);
    #1;
    bus.stsValid = 1'b0;
    chk("t6_sat", 64'(bus.dropCount), 64'd255);

    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) bus.intMask = 4'($urandom);
      if (n % 97 == 0) bus.irqEnable = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 9) < 6, 4'($urandom), 2'($urandom), $urandom,
            $urandom_range(0, 9) < 4, $urandom_range(0, 49) == 0);
    end

    bus.intMask = 4'hF;
    send(32'h1234);
    send(32'h5678);
    @(posedge clock);
    #3;
    resetn = 1'b0;
    #1;
    chk("t6_rready", 64'(bus.stsReady), 64'd1);
    chk("t6_rcount", 64'(bus.fifoCount), 64'd0);
    chk("t6_rhead", {bus.headValid, bus.headEvents, bus.headExtDscrptrAddr}, 64'd0);
    chk("t6_rovf", {bus.overflow, bus.dropCount, bus.irq}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    send(32'h77);
    chk("t6_after", 64'(bus.headExtDscrptrAddr), 64'h77);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
